// File: rtl/watch_timekeeper.sv
// Digital watch (HH:MM:SS) with a 0-99 second stopwatch, both driven from one clock.
// Reset asserts asynchronously and releases through a two-flop synchroniser.
module watch_timekeeper #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [5:0] seconds_initial,
   input  logic [5:0] minutes_initial,
   input  logic [4:0] hours_initial,
   input  logic       start_stopwatch,
   input  logic       reset_stopwatch,
   output logic [5:0] digitalwatch_second,
   output logic [5:0] digitalwatch_minute,
   output logic [4:0] digitalwatch_hour,
   output logic [6:0] stopwatch_second,
   output logic       tick_1hz
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_PAUSE} sw_state_t;

   logic [1:0]    rst_sync_q, rst_sync_d;
   logic          rst_int_n;
   logic [PW-1:0] wpresc_q, wpresc_d;
   logic          tick_q, tick_d;
   logic [5:0]    sec_q, sec_d, min_q, min_d;
   logic [4:0]    hour_q, hour_d;
   logic          start_prev_q, start_prev_d;
   logic          start_edge;
   sw_state_t     sw_state_q, sw_state_d;
   logic [PW-1:0] swpresc_q, swpresc_d;
   logic [6:0]    sw_sec_q, sw_sec_d;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_int_n  = rst_sync_q[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= rst_sync_d;
   end

   // Timekeeping: a load overrides counting, an out-of-range field loads as zero.
   always_comb begin
      wpresc_d = wpresc_q;
      tick_d   = 1'b0;
      sec_d    = sec_q;
      min_d    = min_q;
      hour_d   = hour_q;
      if (load) begin
         sec_d    = (seconds_initial > 6'd59) ? 6'd0 : seconds_initial;
         min_d    = (minutes_initial > 6'd59) ? 6'd0 : minutes_initial;
         hour_d   = (hours_initial > 5'd23) ? 5'd0 : hours_initial;
         wpresc_d = '0;
      end else if (wpresc_q == PRESC_MAX) begin
         wpresc_d = '0;
         tick_d   = 1'b1;
         if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
               min_d  = 6'd0;
               hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end else begin
         wpresc_d = wpresc_q + 1'b1;
      end
   end

   assign start_prev_d = start_stopwatch;
   assign start_edge   = start_stopwatch & ~start_prev_q;

   // Stopwatch: the prescaler advances only while running and is kept across a pause.
   always_comb begin
      sw_state_d = sw_state_q;
      swpresc_d  = swpresc_q;
      sw_sec_d   = sw_sec_q;
      if (reset_stopwatch) begin
         sw_state_d = SW_IDLE;
         swpresc_d  = '0;
         sw_sec_d   = 7'd0;
      end else begin
         case (sw_state_q)
            SW_IDLE: begin
               if (start_edge) begin
                  sw_state_d = SW_RUN;
                  swpresc_d  = '0;
               end
            end
            SW_RUN: begin
               if (start_edge) begin
                  sw_state_d = SW_PAUSE;
               end else if (swpresc_q == PRESC_MAX) begin
                  swpresc_d = '0;
                  sw_sec_d  = (sw_sec_q == 7'd99) ? 7'd0 : sw_sec_q + 7'd1;
               end else begin
                  swpresc_d = swpresc_q + 1'b1;
               end
            end
            SW_PAUSE: begin
               if (start_edge) sw_state_d = SW_RUN;
            end
            default: sw_state_d = SW_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         wpresc_q     <= '0;
         tick_q       <= 1'b0;
         sec_q        <= 6'd0;
         min_q        <= 6'd0;
         hour_q       <= 5'd0;
         start_prev_q <= 1'b0;
         sw_state_q   <= SW_IDLE;
         swpresc_q    <= '0;
         sw_sec_q     <= 7'd0;
      end else begin
         wpresc_q     <= wpresc_d;
         tick_q       <= tick_d;
         sec_q        <= sec_d;
         min_q        <= min_d;
         hour_q       <= hour_d;
         start_prev_q <= start_prev_d;
         sw_state_q   <= sw_state_d;
         swpresc_q    <= swpresc_d;
         sw_sec_q     <= sw_sec_d;
      end
   end

   assign digitalwatch_second = sec_q;
   assign digitalwatch_minute = min_q;
   assign digitalwatch_hour   = hour_q;
   assign stopwatch_second    = sw_sec_q;
   assign tick_1hz            = tick_q;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Self-checking bench for watch_timekeeper with TICK_DIV=4, compared against a
// seconds-of-day / elapsed-run-cycles reference model.
module tb_watch_timekeeper;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       load = 1'b0;
   logic [5:0] seconds_initial = '0;
   logic [5:0] minutes_initial = '0;
   logic [4:0] hours_initial = '0;
   logic       start_stopwatch = 1'b0;
   logic       reset_stopwatch = 1'b0;
   logic [5:0] digitalwatch_second, digitalwatch_minute;
   logic [4:0] digitalwatch_hour;
   logic [6:0] stopwatch_second;
   logic       tick_1hz;

   int n_checks = 0;
   int n_pass = 0;

   // Reference model state
   int m_tod, m_cyc, m_tick, m_mode, m_run, m_prev, m_rel;

   watch_timekeeper #(.TICK_DIV(TD)) dut (
      .clk(clk), .reset_n(reset_n), .load(load),
      .seconds_initial(seconds_initial), .minutes_initial(minutes_initial),
      .hours_initial(hours_initial), .start_stopwatch(start_stopwatch),
      .reset_stopwatch(reset_stopwatch),
      .digitalwatch_second(digitalwatch_second), .digitalwatch_minute(digitalwatch_minute),
      .digitalwatch_hour(digitalwatch_hour), .stopwatch_second(stopwatch_second),
      .tick_1hz(tick_1hz)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL timeout: simulation did not finish, got running required finished");
      $fatal(1);
   end

   function automatic int san(input int v, input int lim);
      return (v > lim) ? 0 : v;
   endfunction

   function automatic logic [16:0] exp_time();
      return {5'(m_tod / 3600), 6'((m_tod / 60) % 60), 6'(m_tod % 60)};
   endfunction

   function automatic logic [6:0] exp_sw();
      return 7'((m_run / TD) % 100);
   endfunction

   function automatic logic [16:0] got_time();
      return {digitalwatch_hour, digitalwatch_minute, digitalwatch_second};
   endfunction

   task automatic model_reset();
      m_tod = 0; m_cyc = 0; m_tick = 0; m_mode = 0; m_run = 0; m_prev = 0; m_rel = 0;
   endtask

   task automatic model_step();
      int e;
      if (load) begin
         m_tod  = san(int'(hours_initial), 23) * 3600 + san(int'(minutes_initial), 59) * 60
                + san(int'(seconds_initial), 59);
         m_cyc  = 0;
         m_tick = 0;
      end else begin
         m_cyc++;
         m_tick = (m_cyc % TD == 0) ? 1 : 0;
         if (m_tick == 1) m_tod = (m_tod + 1) % 86400;
      end
      e = (start_stopwatch && m_prev == 0) ? 1 : 0;
      m_prev = int'(start_stopwatch);
      if (reset_stopwatch) begin
         m_mode = 0; m_run = 0;
      end else if (m_mode == 0) begin
         if (e == 1) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
         if (e == 1) m_mode = 2;
         else m_run++;
      end else if (e == 1) begin
         m_mode = 1;
      end
   endtask

   // One clock: the model sees the inputs the DUT samples; outputs are observed 1ns later.
   task automatic cycle();
      @(posedge clk);
      if (reset_n) begin
         if (m_rel < 2) m_rel++;
         else model_step();
      end
      #1;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      model_reset();
      repeat (3) cycle();
      n_checks++;
      if ({got_time(), stopwatch_second, tick_1hz} !== 25'd0) begin
         $display("[TB] FAIL reset_state: got %h required 0", {got_time(), stopwatch_second, tick_1hz});
      end else n_pass++;
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle();
         n_checks++;
         if ({got_time(), stopwatch_second, tick_1hz} !== 25'd0) begin
            $display("[TB] FAIL reset_sync_hold %0d: got %h required 0", i, {got_time(), stopwatch_second, tick_1hz});
         end else n_pass++;
      end
   endtask

   task automatic test_watch_count();
      int ticks = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (tick_1hz) ticks++;
         n_checks++;
         if ({got_time(), tick_1hz} !== {exp_time(), 1'(m_tick)}) begin
            $display("[TB] FAIL watch_count cyc %0d: got %h/%b required %h/%0d", i, got_time(), tick_1hz, exp_time(), m_tick);
         end else n_pass++;
      end
      n_checks++;
      if (got_time() !== {5'd0, 6'd0, 6'd3} || ticks != 3) begin
         $display("[TB] FAIL watch_count_end: got time %h ticks %0d required 00003 ticks 3", got_time(), ticks);
      end else n_pass++;
   endtask

   task automatic test_load_wrap();
      load = 1'b1; hours_initial = 5'd23; minutes_initial = 6'd59; seconds_initial = 6'd58;
      cycle();
      load = 1'b0;
      n_checks++;
      if ({got_time(), tick_1hz} !== {5'd23, 6'd59, 6'd58, 1'b0}) begin
         $display("[TB] FAIL load_value: got %h/%b required 23:59:58/0", got_time(), tick_1hz);
      end else n_pass++;
      for (int i = 0; i < 8; i++) begin
         cycle();
         n_checks++;
         if ({got_time(), tick_1hz} !== {exp_time(), 1'(m_tick)}) begin
            $display("[TB] FAIL load_wrap cyc %0d: got %h/%b required %h/%0d", i, got_time(), tick_1hz, exp_time(), m_tick);
         end else n_pass++;
      end
      n_checks++;
      if (got_time() !== 17'd0) begin
         $display("[TB] FAIL midnight_wrap: got %h required 0", got_time());
      end else n_pass++;
   endtask

   task automatic test_load_range();
      load = 1'b1; seconds_initial = 6'd61; minutes_initial = 6'd30; hours_initial = 5'd25;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++;
         if (got_time() !== {5'd0, 6'd30, 6'd0} || got_time() !== exp_time()) begin
            $display("[TB] FAIL load_range held %0d: got %h required %h", i, got_time(), {5'd0, 6'd30, 6'd0});
         end else n_pass++;
      end
      for (int i = 0; i < 10; i++) begin
         seconds_initial = 6'($urandom_range(50, 63));
         minutes_initial = 6'($urandom_range(50, 63));
         hours_initial   = 5'($urandom_range(18, 31));
         cycle();
         n_checks++;
         if (got_time() !== exp_time()) begin
            $display("[TB] FAIL load_range rnd %0d: got %h required %h", i, got_time(), exp_time());
         end else n_pass++;
      end
      load = 1'b0;
   endtask

   task automatic test_stopwatch();
      logic [6:0] frozen;
      int bad = 0;
      start_stopwatch = 1'b1;
      cycle();
      start_stopwatch = 1'b0;
      for (int i = 1; i < 400; i++) begin
         cycle();
         if (stopwatch_second !== exp_sw()) bad++;
      end
      n_checks++;
      if (bad != 0 || stopwatch_second !== 7'd99) begin
         $display("[TB] FAIL sw_run_to_99: got %0d (%0d model misses) required 99", stopwatch_second, bad);
      end else n_pass++;
      repeat (4) cycle();
      n_checks++;
      if (stopwatch_second !== 7'd0 || stopwatch_second !== exp_sw()) begin
         $display("[TB] FAIL sw_wrap_99: got %0d required 0", stopwatch_second);
      end else n_pass++;
      start_stopwatch = 1'b1;
      cycle();
      start_stopwatch = 1'b0;
      frozen = stopwatch_second;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (stopwatch_second !== frozen || stopwatch_second !== exp_sw()) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         $display("[TB] FAIL sw_pause: got %0d changes required value frozen at %0d", bad, frozen);
      end else n_pass++;
      start_stopwatch = 1'b1;
      cycle();
      start_stopwatch = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         n_checks++;
         if (stopwatch_second !== exp_sw()) begin
            $display("[TB] FAIL sw_resume cyc %0d: got %0d required %0d", i, stopwatch_second, exp_sw());
         end else n_pass++;
      end
   endtask

   task automatic test_start_held();
      reset_stopwatch = 1'b1;
      cycle();
      reset_stopwatch = 1'b0;
      start_stopwatch = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (i % 8 == 7) begin
            n_checks++;
            if (stopwatch_second !== exp_sw()) begin
               $display("[TB] FAIL start_held cyc %0d: got %0d required %0d", i, stopwatch_second, exp_sw());
            end else n_pass++;
         end
      end
      n_checks++;
      if (stopwatch_second !== 7'd9) begin
         $display("[TB] FAIL start_held_end: got %0d required 9", stopwatch_second);
      end else n_pass++;
      start_stopwatch = 1'b0;
      repeat (3) cycle();
      start_stopwatch = 1'b1;
      reset_stopwatch = 1'b1;
      cycle();
      start_stopwatch = 1'b0;
      reset_stopwatch = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         n_checks++;
         if (stopwatch_second !== 7'd0 || m_mode != 0) begin
            $display("[TB] FAIL sw_reset_priority cyc %0d: got %0d required 0 in idle", i, stopwatch_second);
         end else n_pass++;
      end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 300; i++) begin
         load            = ($urandom_range(0, 19) == 0);
         seconds_initial = 6'($urandom_range(0, 63));
         minutes_initial = 6'($urandom_range(0, 63));
         hours_initial   = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 9) == 0) start_stopwatch = ~start_stopwatch;
         reset_stopwatch = ($urandom_range(0, 49) == 0);
         cycle();
         n_checks++;
         if ({got_time(), stopwatch_second, tick_1hz} !== {exp_time(), exp_sw(), 1'(m_tick)}) begin
            bad++;
            if (bad < 10)
               $display("[TB] FAIL random cyc %0d: got %h/%0d/%b required %h/%0d/%0d", i, got_time(),
                        stopwatch_second, tick_1hz, exp_time(), exp_sw(), m_tick);
         end else n_pass++;
      end
      load = 1'b0; start_stopwatch = 1'b0; reset_stopwatch = 1'b0;
      cycle();
   endtask

   task automatic test_async_reset();
      reset_stopwatch = 1'b1;
      cycle();
      reset_stopwatch = 1'b0;
      start_stopwatch = 1'b1;
      cycle();
      start_stopwatch = 1'b0;
      repeat (147) cycle();
      load = 1'b1; hours_initial = 5'd10; minutes_initial = 6'd20; seconds_initial = 6'd30;
      cycle();
      load = 1'b0;
      n_checks++;
      if ({got_time(), stopwatch_second} !== {5'd10, 6'd20, 6'd30, 7'd37}) begin
         $display("[TB] FAIL async_pre: got %h/%0d required 10:20:30/37", got_time(), stopwatch_second);
      end else n_pass++;
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({got_time(), stopwatch_second, tick_1hz} !== 25'd0) begin
         $display("[TB] FAIL async_reset: got %h required 0 before clock", {got_time(), stopwatch_second, tick_1hz});
      end else n_pass++;
      cycle();
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         n_checks++;
         if ({got_time(), stopwatch_second, tick_1hz} !== {exp_time(), exp_sw(), 1'(m_tick)} || stopwatch_second !== 7'd0) begin
            $display("[TB] FAIL async_release cyc %0d: got %h/%0d/%b required %h/0/%0d", i, got_time(),
                     stopwatch_second, tick_1hz, exp_time(), m_tick);
         end else n_pass++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_watch_count();
      test_load_wrap();
      test_load_range();
      test_stopwatch();
      test_start_held();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/watch_timekeeper.md
WATCH_TIMEKEEPER -- requirements
Module: watch_timekeeper

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clk cycles per second (legal >= 2).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low; one clock only.
REQ-004 SHALL have port load  input  1  sync load of initial time, level-sensitive.
REQ-005 SHALL have ports seconds_initial, minutes_initial  input  6 each  initial sec/min, binary.
REQ-006 SHALL have port hours_initial  input  5  initial hour, binary.
REQ-007 SHALL have port start_stopwatch  input  1  stopwatch start/pause toggle, rising-edge detected.
REQ-008 SHALL have port reset_stopwatch  input  1  sync stopwatch clear, level-sensitive.
REQ-009 SHALL have ports digitalwatch_second, digitalwatch_minute  output  6 each  registered time, 0-59.
REQ-010 SHALL have port digitalwatch_hour  output  5  registered hour, 0-23.
REQ-011 SHALL have port stopwatch_second  output  7  registered stopwatch count, 0-99.
REQ-012 SHALL have port tick_1hz  output  1  one-cycle pulse per elapsed watch second.

Function
REQ-013 Watch prescaler SHALL count 0..TICK_DIV-1, wrap to 0; tick_1hz=1 only in the cycle after count TICK_DIV-1 (registered).
REQ-014 On each tick: second+1; at 59 -> 0 and minute+1; minute 59 -> 0 and hour+1; hour 23 -> 0 (23:59:59 -> 00:00:00 in one tick).
REQ-015 load=1 SHALL override counting: time regs <= initial values next edge, watch prescaler <= 0, tick_1hz <= 0; held load holds time.
REQ-016 Out-of-range load value (sec/min > 59, hour > 23) SHALL be loaded as 0, per field independently.
REQ-017 Stopwatch FSM states IDLE, RUN, PAUSE; reset state IDLE.
REQ-018 start edge = start_stopwatch 1 now and 0 in previous cycle (one input register); level held = one edge only.
REQ-019 IDLE --edge--> RUN, stopwatch prescaler <= 0; RUN --edge--> PAUSE; PAUSE --edge--> RUN, prescaler resumes from held value.
REQ-020 Stopwatch prescaler SHALL count 0..TICK_DIV-1 only in RUN; at wrap stopwatch_second+1, 99 -> 0.
REQ-021 reset_stopwatch=1 SHALL force FSM IDLE, stopwatch_second 0, prescaler 0 next edge; priority over start edge same cycle.
REQ-022 Stopwatch SHALL be independent of load and watch tick; load does not affect stopwatch.
REQ-023 All outputs driven directly from flops; no combinational input-to-output path.
REQ-024 Latency: input change (load, reset_stopwatch, start edge) visible on outputs exactly one edge after sampling, except start edge (two edges, REQ-018 register).

Reset
REQ-025 reset_n=0 SHALL immediately (no clock) clear all time regs, stopwatch_second, both prescalers, tick_1hz, edge register to 0 and FSM to IDLE.
REQ-026 Deassertion SHALL be synchronised (two-flop) before releasing logic; first tick TICK_DIV cycles after synchronised release.
REQ-027 Reset assertion mid-count or mid-load SHALL abort; no partial field update survives.

Verification (TICK_DIV=4 unless noted)
REQ-028 Reset, release, run 12 cycles -> tick_1hz pulses every 4 cycles, digitalwatch_second 0->1->2->3, others 0.
REQ-029 load with 23/59/58 (h/m/s), release, 8 cycles -> 23:59:59 then 00:00:00, tick_1hz each step.
REQ-030 load with seconds_initial=61, minutes_initial=30, hours_initial=25 -> outputs 0/30/0 (s/m/h).
REQ-031 start pulse, 400 cycles -> stopwatch_second 99; 4 more -> 0; second start pulse -> value frozen 20 cycles; third pulse -> resumes.
REQ-032 start held high 40 cycles -> one edge only, stopwatch counts continuously; reset_stopwatch with start edge same cycle -> IDLE, 0.
REQ-033 reset_n pulled low between edges mid-RUN at stopwatch 37, time 10:20:30 -> all outputs 0 before next clk edge, FSM IDLE.
